// File: rtl/hazard_ctrl_v2.sv
// Hazard and pipeline-control unit for the 5-stage MIPS core: forwarding selects, RAW stalls,
// an internal divide sequencer and per-stage stall/flush. Optional exception flush path: EXC_FLUSH_EN.
module hazard_ctrl_v2 #(
    parameter int REG_ADDR_W = 5,
    parameter int DIV_LAT    = 32,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rsD,
    input  logic [REG_ADDR_W-1:0] rtD,
    input  logic                  branchD,
    input  logic                  jumpregD,
    input  logic [REG_ADDR_W-1:0] rsE,
    input  logic [REG_ADDR_W-1:0] rtE,
    input  logic [REG_ADDR_W-1:0] writeregE,
    input  logic                  regwriteE,
    input  logic                  memtoregE,
    input  logic                  divE,
    input  logic [REG_ADDR_W-1:0] writeregM,
    input  logic                  regwriteM,
    input  logic                  memtoregM,
    input  logic [REG_ADDR_W-1:0] writeregW,
    input  logic                  regwriteW,
    output logic                  forwardaD,
    output logic                  forwardbD,
    output logic [1:0]            forwardaE,
    output logic [1:0]            forwardbE,
    output logic                  lwstallD,
    output logic                  branchstallD,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  flushE,
    output logic                  flushM,
`ifdef EXC_FLUSH_EN
    input  logic                  exceptM,
    output logic                  flushF,
    output logic                  flushD,
    output logic                  flushW,
`endif
    output logic                  div_busy,
    output logic                  div_doneE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(DIV_LAT - 1);

    genvar gi;

    // ------------------------------------------------------------------
    // E-stage forwarding: operand 0 is rs, operand 1 is rt; M beats W
    // ------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] w_src_e [2];
    logic [1:0]            w_fwd_e [2];

    assign w_src_e[0] = rsE;
    assign w_src_e[1] = rtE;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd_e
            logic w_nz;
            logic w_hit_m;
            logic w_hit_w;

            assign w_nz    = (w_src_e[gi] != '0);
            assign w_hit_m = w_nz & regwriteM & (w_src_e[gi] == writeregM);
            assign w_hit_w = w_nz & regwriteW & (w_src_e[gi] == writeregW);
            assign w_fwd_e[gi] = w_hit_m ? 2'b10 : (w_hit_w ? 2'b01 : 2'b00);
        end
    endgenerate

    assign forwardaE = w_fwd_e[0];
    assign forwardbE = w_fwd_e[1];

    // ------------------------------------------------------------------
    // D-stage terms: compare forwarding, load-use and branch RAW hits
    // ------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] w_src_d [2];
    logic [1:0]            w_used_d;
    logic [1:0]            w_fwd_d;
    logic [1:0]            w_raw_d;
    logic [1:0]            w_lw_d;
    logic                  w_rte_nz;

    assign w_src_d[0] = rsD;
    assign w_src_d[1] = rtD;
    assign w_used_d[0] = branchD | jumpregD;
    assign w_used_d[1] = branchD;
    assign w_rte_nz    = (rtE != '0);

    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_d
            logic w_nz;
            logic w_hit_e;
            logic w_hit_m_ld;

            assign w_nz        = (w_src_d[gi] != '0);
            assign w_hit_e     = regwriteE & (w_src_d[gi] == writeregE);
            assign w_hit_m_ld  = memtoregM & (w_src_d[gi] == writeregM);
            assign w_fwd_d[gi] = w_nz & regwriteM & (w_src_d[gi] == writeregM);
            assign w_raw_d[gi] = w_used_d[gi] & w_nz & (w_hit_e | w_hit_m_ld);
            assign w_lw_d[gi]  = memtoregE & w_rte_nz & (rtE == w_src_d[gi]);
        end
    endgenerate

    assign forwardaD    = w_fwd_d[0];
    assign forwardbD    = w_fwd_d[1];
    assign lwstallD     = |w_lw_d;
    assign branchstallD = |w_raw_d;

    // ------------------------------------------------------------------
    // Divide sequencer
    // ------------------------------------------------------------------
    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_div_hold;
    logic             w_abort;

`ifdef EXC_FLUSH_EN
    assign w_abort = exceptM;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (divE) begin
                    w_state_next = S_BUSY;
                    w_cnt_next   = LP_CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            // divE is still high here for the finishing divide; it must not restart.
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
        end
    end

    always_comb begin
        w_div_hold = 1'b0;
        div_busy   = 1'b0;
        div_doneE  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_div_hold = divE;
            end
            S_BUSY: begin
                w_div_hold = 1'b1;
                div_busy   = 1'b1;
            end
            S_DONE: begin
                div_busy  = 1'b1;
                div_doneE = 1'b1;
            end
            default: begin
                w_div_hold = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall / flush: a held E is never flushed; M gets the bubble instead
    // ------------------------------------------------------------------
    logic w_raw_stall;

    assign w_raw_stall = lwstallD | branchstallD;

    always_comb begin
        stallE = w_div_hold;
        stallD = w_raw_stall | w_div_hold;
        stallF = w_raw_stall | w_div_hold;
        flushE = w_raw_stall & ~w_div_hold;
        flushM = w_div_hold;
`ifdef EXC_FLUSH_EN
        flushF = 1'b0;
        flushD = 1'b0;
        flushW = 1'b0;
        if (exceptM) begin
            stallF = 1'b0;
            stallD = 1'b0;
            stallE = 1'b0;
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end
`endif
    end

endmodule
